// File: rtl/ksa_pkg.sv
// Shared definitions for the pipelined Kogge-Stone adder: level count helper
// and the bundle that travels between prefix stages.
package ksa_pkg;

    // Widest operand the stage bundle can carry; bits above N stay zero.
    localparam int KSA_MAX_N = 128;

    typedef struct packed {
        logic                 valid;
        logic                 cin;
        logic [KSA_MAX_N-1:0] p;
        logic [KSA_MAX_N-1:0] g_grp;
        logic [KSA_MAX_N-1:0] p_grp;
    } ksa_stage_t;

    function automatic int ksa_levels(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/ksa_prefix_stage.sv
// One Kogge-Stone prefix level at distance DIST, followed by its pipeline
// register. The original p vector, cin and valid ride along untouched.
module ksa_prefix_stage
    import ksa_pkg::*;
#(
    parameter int N    = 32,
    parameter int DIST = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  ksa_stage_t stage_in,
    output ksa_stage_t stage_out
);

    ksa_stage_t nxt;

    always_comb begin
        nxt = stage_in;
        // Bits below DIST have no partner at i-DIST and keep their group terms.
        for (int i = DIST; i < N; i++) begin
            nxt.g_grp[i] = stage_in.g_grp[i] | (stage_in.p_grp[i] & stage_in.g_grp[i-DIST]);
            nxt.p_grp[i] = stage_in.p_grp[i] & stage_in.p_grp[i-DIST];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stage_out <= '0;
        end else if (en) begin
            stage_out <= nxt;
        end
    end

endmodule

// File: rtl/ksa_pipe.sv
// Pipelined, flow-controlled Kogge-Stone adder: pg stage, LEVELS prefix
// stages and a sum/carry output register, all under one global stall.
module ksa_pipe
    import ksa_pkg::*;
#(
    parameter int N      = 32,
    parameter int LEVELS = ksa_levels(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         cout
);

    // Handshake: a transfer happens on a clk edge where valid & ready are both
    // high. The whole pipe advances only when the output slot is empty or is
    // being consumed, so in_ready is that advance condition.
    logic adv;

    ksa_stage_t   stage0_nxt;
    ksa_stage_t   stage0_q;
    ksa_stage_t   chain [LEVELS+1];
    logic [N-1:0] g_top;
    logic [N-1:0] p_top;
    logic [N-1:0] carry;
    logic         unused_final;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    always_comb begin
        stage0_nxt                = '0;
        stage0_nxt.valid          = in_valid;
        stage0_nxt.cin            = cin;
        stage0_nxt.p[N-1:0]       = a ^ b;
        stage0_nxt.p_grp[N-1:0]   = a ^ b;
        stage0_nxt.g_grp[N-1:0]   = a & b;
        // Fold cin into bit 0 so the prefix tree yields carries including cin.
        stage0_nxt.g_grp[0]       = (a[0] & b[0]) | ((a[0] ^ b[0]) & cin);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stage0_q <= '0;
        end else if (adv) begin
            stage0_q <= stage0_nxt;
        end
    end

    assign chain[0] = stage0_q;

    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        ksa_prefix_stage #(
            .N    (N),
            .DIST (1 << k)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .en        (adv),
            .stage_in  (chain[k]),
            .stage_out (chain[k+1])
        );
    end

    assign g_top        = chain[LEVELS].g_grp[N-1:0];
    assign p_top        = chain[LEVELS].p[N-1:0];
    assign carry        = {g_top[N-2:0], chain[LEVELS].cin};
    assign unused_final = ^chain[LEVELS];

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            s         <= '0;
            cout      <= 1'b0;
        end else if (adv) begin
            out_valid <= chain[LEVELS].valid;
            s         <= p_top ^ carry;
            cout      <= g_top[N-1];
        end
    end

endmodule

// File: tb/tb_ksa_pipe.sv
// Bench for ksa_pipe: N=32 and N=2 instances, directed vector table plus
// streaming, backpressure, bubble and mid-flight reset sequences.
module tb_ksa_pipe;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, out_valid, out_ready, cin, cout;
    logic [W-1:0] a, b, s;

    logic         in_valid2, in_ready2, out_valid2, out_ready2, cin2, cout2;
    logic [1:0]   a2, b2, s2;

    ksa_pipe #(.N(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cout(cout)
    );

    ksa_pipe #(.N(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .cin(cin2), .out_valid(out_valid2), .out_ready(out_ready2),
        .s(s2), .cout(cout2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         cout;
    } vec_t;

    int checks = 0;
    int failures = 0;
    logic [W:0] exp_q[$];
    logic [2:0] exp2_q[$];
    int cyc = 0;
    int n_out = 0, first_out = -1, last_out = -1;
    int n_out2 = 0, first_out2 = -1;
    logic bp_mode = 1'b0;
    int bp_idx = 0;
    logic prev_stall = 1'b0;
    logic [W:0] prev_res = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Consumer: always ready, or the 1,0,0,1,0 pattern in backpressure mode.
    always @(posedge clk) begin
        #1;
        if (bp_mode) begin
            out_ready = (bp_idx % 5 == 0) || (bp_idx % 5 == 3);
            bp_idx++;
        end else begin
            out_ready = 1'b1;
        end
    end

    // Scoreboard and stall-stability monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset) begin
            if (prev_stall) begin
                check("stall_valid_hold", {63'd0, out_valid}, 64'd1);
                check("stall_data_hold", {31'd0, cout, s}, {31'd0, prev_res});
            end
            if (out_valid && !out_ready) check("stall_in_ready", {63'd0, in_ready}, 64'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out: got %0h expected no output", {cout, s});
                end else begin
                    check("result", {31'd0, cout, s}, {31'd0, exp_q.pop_front()});
                end
                n_out++;
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = {cout, s};
            if (out_valid2 && out_ready2) begin
                if (exp2_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out2: got %0h expected no output", {cout2, s2});
                end else begin
                    check("result_n2", {61'd0, cout2, s2}, {61'd0, exp2_q.pop_front()});
                end
                n_out2++;
                if (first_out2 < 0) first_out2 = cyc;
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic measure(input vec_t v, input string name);
        int lat;
        @(posedge clk); #1;
        a = v.a; b = v.b; cin = v.cin; in_valid = 1'b1;
        @(negedge clk);
        check({name, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        exp_q.push_back({v.cout, v.s});
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; cin = 1'b1;
        lat = 1;
        while (lat < 20) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            lat++;
        end
        check({name, "_latency"}, lat, 64'd7);
    endtask

    task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
        int tries = 0;
        logic acc = 1'b0;
        @(posedge clk); #1;
        a = va; b = vb; cin = vc; in_valid = 1'b1;
        while (!acc && tries < 200) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) exp_q.push_back({1'b0, va} + {1'b0, vb} + {{W{1'b0}}, vc});
            else begin
                @(posedge clk);
                tries++;
            end
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected acceptance", tries);
        end
    endtask

    task automatic idle_input();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        check(name, exp_q.size(), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[11];
        int base, ov_cnt, acc2_cyc;

        vecs[0]  = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
        vecs[1]  = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
        vecs[2]  = '{32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0};
        vecs[3]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
        vecs[4]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
        vecs[5]  = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0};
        vecs[6]  = '{32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 1'b0};
        vecs[7]  = '{32'hAAAAAAAA, 32'h55555555, 1'b0, 32'hFFFFFFFF, 1'b0};
        vecs[8]  = '{32'hAAAAAAAA, 32'h55555555, 1'b1, 32'h00000000, 1'b1};
        vecs[9]  = '{32'hDEADBEEF, 32'h00000001, 1'b0, 32'hDEADBEF0, 1'b0};
        vecs[10] = '{32'h0000FFFF, 32'h00000001, 1'b1, 32'h00010001, 1'b0};

        reset = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
        in_valid2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0; out_ready2 = 1'b1;

        // Reset held three cycles, then idle.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (i == 3) reset = 1'b1;
            @(negedge clk);
            check("reset_out_valid", {63'd0, out_valid}, 64'd0);
            check("reset_sum", {31'd0, cout, s}, 64'd0);
            check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        end

        // Directed vectors, each on an empty pipe with latency measured.
        for (int i = 0; i < 11; i++) measure(vecs[i], $sformatf("vec%0d", i));
        drain("vec_drain");

        // Back-to-back random stream.
        base = n_out; first_out = -1;
        for (int i = 0; i < 100; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)));
        idle_input();
        drain("stream_drain");
        check("stream_count", n_out - base, 64'd100);
        check("stream_consecutive", last_out - first_out, 64'd99);

        // Backpressure with out_ready pattern 1,0,0,1,0.
        base = n_out; bp_idx = 0; bp_mode = 1'b1;
        for (int i = 0; i < 20; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)));
        idle_input();
        drain("bp_drain");
        bp_mode = 1'b0;
        check("bp_count", n_out - base, 64'd20);

        // Bubbles: in_valid 1,0,1,1,0 with a=i, b=2i.
        base = n_out;
        exp_q.push_back(33'd0);
        exp_q.push_back(33'd6);
        exp_q.push_back(33'd9);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            a = W'(i); b = W'(2 * i); cin = 1'b0;
            in_valid = (i == 0) || (i == 2) || (i == 3);
        end
        idle_input();
        drain("bubble_drain");
        check("bubble_count", n_out - base, 64'd3);

        // Reset mid-flight: ops on cycles 0..3, reset asserted on cycle 3.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            a = W'(i + 100); b = W'(i); cin = 1'b1; in_valid = 1'b1;
            if (i == 3) reset = 1'b0;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; reset = 1'b1;
        ov_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) ov_cnt++;
        end
        check("reset_flight_no_out", ov_cnt, 64'd0);
        measure(vecs[5], "post_reset");
        drain("post_reset_drain");

        // N=2 exhaustive sweep, back to back.
        acc2_cyc = 0;
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            a2 = i[4:3]; b2 = i[2:1]; cin2 = i[0]; in_valid2 = 1'b1;
            @(negedge clk);
            check("n2_in_ready", {63'd0, in_ready2}, 64'd1);
            if (i == 0) acc2_cyc = cyc;
            exp2_q.push_back({1'b0, a2} + {1'b0, b2} + {2'b00, cin2});
        end
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        for (int k = 0; k < 50 && exp2_q.size() != 0; k++) @(negedge clk);
        @(negedge clk);
        check("n2_drain", exp2_q.size(), 64'd0);
        check("n2_count", n_out2, 64'd32);
        check("n2_latency", first_out2 - acc2_cyc, 64'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
